// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a small byte FIFO
// drained through a valid/ready port; framing and overflow errors are sticky.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       deq_valid,
    input  logic       deq_ready,
    output logic [7:0] deq_bits,
    output logic       frame_err,
    output logic       overflow,
    input  logic       err_clear,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HalfLoad = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FullLoad = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [PW:0]   PtrOne   = (PW + 1)'(1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rs_q;
    logic          busy_q;
    logic          push, ferr_set;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, pop, push_ok, ovf_set;
    logic          frame_err_q, overflow_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (cnt_q != '0) cnt_d = cnt_q - CntOne;
        unique case (state_q)
            StIdle: begin
                if (!rs_q) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                // A start bit that is high again at its midpoint is a glitch.
                if (cnt_q == '0) begin
                    if (rs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                        idx_d   = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rs_q;
                    cnt_d          = FullLoad;
                    if (idx_q == 3'd7) state_d = StStop;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            StStop: begin
                // Leave at mid-stop-bit so a following start bit is not missed.
                if (cnt_q == '0) begin
                    if (rs_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rs_q      <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop     = !empty && deq_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[PW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + PtrOne;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (ferr_set)       frame_err_q <= 1'b1;
            else if (err_clear) frame_err_q <= 1'b0;
            if (ovf_set)        overflow_q  <= 1'b1;
            else if (err_clear) overflow_q  <= 1'b0;
        end
    end

    assign deq_valid = !empty;
    assign deq_bits  = mem_q[rd_ptr_q[PW-1:0]];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table, directed corner sequences and a
// randomized run checked against a queue-based model of the receive path.
module tb_uart_rx_fifo;

    localparam int CLK_DIV  = 16;
    localparam int DEPTH    = 4;
    // rx fall -> push visible: 2 sync flops + 1 to leave idle, half bit, 9 full bits.
    localparam int PUSH_LAT = 3 + CLK_DIV / 2 + 9 * CLK_DIV;
    localparam int NV       = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       deq_ready = 1'b0;
    logic       err_clear = 1'b0;
    logic       deq_valid, frame_err, overflow, rx_busy;
    logic [7:0] deq_bits;

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clear (err_clear),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_bits;
        logic       exp_ferr;
        logic       exp_busy;
    } vec_t;

    vec_t       vecs[NV];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         busy_cnt;
    logic [7:0] got[$];
    logic [7:0] expq[$];

    bit         model_on = 1'b0;
    bit         done = 1'b0;
    int         push_at = -1;
    logic [7:0] push_byte = '0;
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    int         rdy_pct = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) if (deq_valid && deq_ready) got.push_back(deq_bits);

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_got(input string name);
        chkn({name, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk8(name, (i < got.size()) ? got[i] : 8'hxx, expq[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives the first nbits bit-times of an 8N1 frame; called #1 after a clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr        = {stop_bit, b, 1'b0};
        push_byte = b;
        push_at   = (stop_bit && nbits == 10) ? cyc + PUSH_LAT : -1;
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            repeat (CLK_DIV) @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Receive-path model: a byte lands at the computed push cycle unless the queue is full
    // with no pop in that same cycle.
    always @(negedge clock) begin
        int sz;
        bit mpop;
        bit oset;
        if (model_on) begin
            chk1("rnd_valid", deq_valid, mq.size() != 0);
            if (mq.size() != 0) chk8("rnd_bits", deq_bits, mq[0]);
            chk1("rnd_ovf", overflow, m_ovf);
            chk1("rnd_ferr", frame_err, 1'b0);
            sz   = mq.size();
            mpop = (sz != 0) && deq_ready;
            oset = 1'b0;
            if (mpop) void'(mq.pop_front());
            if (cyc + 1 == push_at) begin
                if (sz < DEPTH || mpop) mq.push_back(push_byte);
                else oset = 1'b1;
            end
            m_ovf = oset ? 1'b1 : (err_clear ? 1'b0 : m_ovf);
        end
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        do_reset();
        chk1("rst_valid", deq_valid, 1'b0);
        chk8("rst_bits", deq_bits, 8'h00);
        chk1("rst_ferr", frame_err, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        chk1("rst_busy", rx_busy, 1'b0);
        tick(3);

        for (int i = 0; i < NV; i++) begin
            deq_ready = 1'b0;
            send_frame(vecs[i].data, vecs[i].stop, 10);
            chk1("tbl_valid", deq_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk8("tbl_bits", deq_bits, vecs[i].exp_bits);
            chk1("tbl_ferr", frame_err, vecs[i].exp_ferr);
            chk1("tbl_busy", rx_busy, vecs[i].exp_busy);
            chk1("tbl_ovf", overflow, 1'b0);
            rx        = 1'b1;
            deq_ready = 1'b1;
            err_clear = 1'b1;
            tick(1);
            deq_ready = 1'b0;
            err_clear = 1'b0;
            tick(4);
            chk1("tbl_drained", deq_valid, 1'b0);
            chk1("tbl_ferr_clr", frame_err, 1'b0);
            chk1("tbl_idle", rx_busy, 1'b0);
        end

        // Exact dequeue latency and single-cycle pop.
        tick(5);
        fork
            send_frame(8'h55, 1'b1, 10);
            begin
                repeat (PUSH_LAT - 1) @(posedge clock);
                #1 chk1("lat_before", deq_valid, 1'b0);
                @(posedge clock);
                #1 chk1("lat_at", deq_valid, 1'b1);
                chk8("lat_bits", deq_bits, 8'h55);
            end
        join
        deq_ready = 1'b1;
        tick(1);
        deq_ready = 1'b0;
        chk1("lat_pop", deq_valid, 1'b0);

        // Back-to-back frames with the consumer always ready.
        tick(5);
        got.delete();
        deq_ready = 1'b1;
        send_frame(8'hA3, 1'b1, 10);
        send_frame(8'h0F, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        tick(5);
        deq_ready = 1'b0;
        expq = '{8'hA3, 8'h0F, 8'hFF};
        check_got("b2b");
        chk1("b2b_ferr", frame_err, 1'b0);
        chk1("b2b_ovf", overflow, 1'b0);

        // Start-bit glitch.
        tick(10);
        busy_cnt = 0;
        rx = 1'b0;
        fork
            begin tick(4); rx = 1'b1; end
            for (int k = 0; k < 30; k++) begin
                @(negedge clock);
                if (rx_busy) busy_cnt++;
            end
        join
        chkn("glitch_busy_cycles", busy_cnt, 8);
        chk1("glitch_busy_end", rx_busy, 1'b0);
        chk1("glitch_valid", deq_valid, 1'b0);
        chk1("glitch_ferr", frame_err, 1'b0);
        chk1("glitch_ovf", overflow, 1'b0);

        // Framing error, break hold, recovery, clear.
        tick(5);
        send_frame(8'h3C, 1'b0, 10);
        tick(40);
        chk1("brk_ferr", frame_err, 1'b1);
        chk1("brk_busy", rx_busy, 1'b1);
        chk1("brk_nopush", deq_valid, 1'b0);
        rx = 1'b1;
        tick(5);
        chk1("brk_exit", rx_busy, 1'b0);
        send_frame(8'h81, 1'b1, 10);
        tick(2);
        chk1("brk_next_valid", deq_valid, 1'b1);
        chk8("brk_next_bits", deq_bits, 8'h81);
        chk1("brk_ferr_held", frame_err, 1'b1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk1("brk_ferr_clr", frame_err, 1'b0);
        deq_ready = 1'b1;
        tick(1);
        deq_ready = 1'b0;

        // Overflow with no consumer.
        tick(5);
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 10);
        chk1("ovf_set", overflow, 1'b1);
        chk8("ovf_head", deq_bits, 8'h01);
        got.delete();
        deq_ready = 1'b1;
        tick(8);
        deq_ready = 1'b0;
        expq = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_got("ovf_drain");
        chk1("ovf_empty", deq_valid, 1'b0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk1("ovf_clr", overflow, 1'b0);

        // Push into a full FIFO in the same cycle as a pop.
        got.delete();
        for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 10);
        fork
            send_frame(8'h05, 1'b1, 10);
            begin
                repeat (PUSH_LAT - 1) @(posedge clock);
                #1 deq_ready = 1'b1;
                @(posedge clock);
                #1 deq_ready = 1'b0;
            end
        join
        chk1("fullpop_ovf", overflow, 1'b0);
        deq_ready = 1'b1;
        tick(8);
        deq_ready = 1'b0;
        expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_got("fullpop");

        // Reset mid-frame with bytes queued and a flag set.
        tick(5);
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        send_frame(8'h3C, 1'b0, 10);
        rx = 1'b1;
        tick(5);
        chk1("pre_rst_ferr", frame_err, 1'b1);
        chk1("pre_rst_valid", deq_valid, 1'b1);
        send_frame(8'h5A, 1'b1, 5);
        reset = 1'b1;
        rx    = 1'b1;
        tick(1);
        reset = 1'b0;
        chk1("mid_rst_valid", deq_valid, 1'b0);
        chk1("mid_rst_busy", rx_busy, 1'b0);
        chk1("mid_rst_ferr", frame_err, 1'b0);
        chk1("mid_rst_ovf", overflow, 1'b0);
        chk8("mid_rst_bits", deq_bits, 8'h00);
        tick(20);
        chk1("post_rst_quiet", deq_valid, 1'b0);
        send_frame(8'hC6, 1'b1, 10);
        tick(2);
        chk1("post_rst_valid", deq_valid, 1'b1);
        chk8("post_rst_bits", deq_bits, 8'hC6);

        // Randomized frames, gaps, consumer readiness and clears against the model.
        do_reset();
        tick(2);
        mq.delete();
        m_ovf    = 1'b0;
        push_at  = -1;
        done     = 1'b0;
        model_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    rdy_pct = (f < 7) ? 0 : int'($urandom_range(10, 60));
                    tick(int'($urandom_range(0, 12)));
                    send_frame(8'($urandom), 1'b1, 10);
                end
                rdy_pct = 100;
                tick(12);
                done = 1'b1;
            end
            while (!done) begin
                deq_ready = (int'($urandom_range(0, 99)) < rdy_pct);
                err_clear = (f_clear_roll() == 0);
                tick(1);
            end
        join
        deq_ready = 1'b0;
        err_clear = 1'b0;
        tick(2);
        model_on = 1'b0;
        chkn("rnd_model_empty", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic int f_clear_roll();
        return int'($urandom_range(0, 199));
    endfunction

endmodule
